conv_layer_sched: RTL



---
 rtl/conv_sched_pkg.sv | 60 ++++++
 rtl/conv_desc_table.sv | 25 ++
 rtl/conv_layer_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolution layer sequencer.
// Descriptor layout, error codes and config register packing.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_CFG,
    S_RUN,
    S_WAIT,
    S_DRAIN,
    S_ERR
  } state_t;

  localparam logic [1:0] LD_MODE_IFMAP_W = 2'b11;
  localparam logic [1:0] LD_MODE_W       = 2'b01;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ZERO    = 2'd1;
  localparam logic [1:0] ERR_DESC    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int DESC_W       = 50;
  localparam int OFS_STRIDE   = 0;
  localparam int OFS_CHANNELS = 8;
  localparam int OFS_KNUMS    = 16;
  localparam int OFS_KSIZE    = 24;
  localparam int OFS_TSIZE    = 32;
  localparam int OFS_SHIFT    = 40;
  localparam int OFS_QUANT    = 48;
  localparam int OFS_RELU     = 49;

  typedef struct packed {
    logic       relu_en;
    logic       quant_en;
    logic [7:0] shift;
    logic [7:0] tensor_size;
    logic [7:0] kernel_size;
    logic [7:0] kernel_nums;
    logic [7:0] channels;
    logic [7:0] stride;
  } desc_t;

  function automatic logic [31:0] pack_reg0(desc_t d);
    return {2'b0, d.tensor_size, 6'b0, d.kernel_size, d.stride};
  endfunction

  function automatic logic [31:0] pack_reg1(desc_t d);
    return {2'b0, d.channels, 2'b0, d.kernel_nums,
            2'b00, d.relu_en, d.quant_en, d.shift};
  endfunction

  function automatic logic desc_bad(desc_t d);
    return (d.kernel_size == 8'd0) || (d.stride == 8'd0) ||
           (d.channels == 8'd0) || (d.kernel_nums == 8'd0) ||
           (d.kernel_size > d.tensor_size);
  endfunction

endpackage

// File: rtl/conv_desc_table.sv
// Per-layer descriptor register file: one write port,
// asynchronous read of the layer in progress.
module conv_desc_table
  import conv_sched_pkg::*;
#(
  parameter  int MAX_LAYERS = 8,
  localparam int AW         = $clog2(MAX_LAYERS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  desc_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output desc_t         rdata_o
);

  desc_t mem_q [MAX_LAYERS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_layer_sched.sv
// Layer sequencer: walks the descriptor table, drives loader,
// config registers and conv enable, then drains the output.
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter  int MAX_LAYERS = 8,
  parameter  int TIMEOUT    = 65535,
  localparam int AW         = $clog2(MAX_LAYERS),
  localparam int NW         = AW + 1,
  localparam int TW         = $clog2(TIMEOUT + 1)
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              desc_we,
  input  logic [AW-1:0]     desc_addr,
  input  logic [DESC_W-1:0] desc_wdata,
  input  logic [NW-1:0]     num_layers,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [AW-1:0]     cur_layer,
  output logic              ld_req,
  output logic [1:0]        ld_mode,
  input  logic              ld_done,
  output logic              cfg_we,
  output logic [31:0]       cfg_reg0,
  output logic [31:0]       cfg_reg1,
  output logic              conv_en,
  input  logic              conv_done,
  output logic              drain_req,
  input  logic              drain_last
);

  state_t        state_q;
  logic [NW-1:0] n_q;
  logic [AW-1:0] cur_layer_q;
  logic [TW-1:0] wdog_q;
  logic [1:0]    err_code_q;
  logic          done_q;
  logic          ld_req_q;
  logic [1:0]    ld_mode_q;
  logic          cfg_we_q;
  logic          conv_en_q;
  logic          drain_req_q;
  logic [31:0]   cfg_reg0_q;
  logic [31:0]   cfg_reg1_q;
  desc_t         rd_desc;
  logic          last_layer;
  logic          wdog_hit;
  logic          tab_we;

  // the table only accepts host writes while the sequencer is parked
  assign tab_we = desc_we && (state_q == S_IDLE);

  conv_desc_table #(.MAX_LAYERS(MAX_LAYERS)) u_tab (
    .clk_i   (s_axi_aclk),
    .we_i    (tab_we),
    .waddr_i (desc_addr),
    .wdata_i (desc_t'(desc_wdata)),
    .raddr_i (cur_layer_q),
    .rdata_o (rd_desc)
  );

  assign last_layer = ({1'b0, cur_layer_q} == n_q - NW'(1));
  assign wdog_hit   = (wdog_q == TW'(TIMEOUT - 1));

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      cur_layer_q <= '0;
      wdog_q      <= '0;
      err_code_q  <= ERR_NONE;
      done_q      <= 1'b0;
      ld_req_q    <= 1'b0;
      ld_mode_q   <= 2'b00;
      cfg_we_q    <= 1'b0;
      conv_en_q   <= 1'b0;
      drain_req_q <= 1'b0;
      cfg_reg0_q  <= '0;
      cfg_reg1_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_we_q  <= 1'b0;
      conv_en_q <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        ld_req_q    <= 1'b0;
        ld_mode_q   <= 2'b00;
        drain_req_q <= 1'b0;
        err_code_q  <= ERR_NONE;
        wdog_q      <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              if (num_layers == '0 ||
                  num_layers > NW'(MAX_LAYERS)) begin
                state_q    <= S_ERR;
                err_code_q <= ERR_ZERO;
              end else begin
                n_q         <= num_layers;
                cur_layer_q <= '0;
                state_q     <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (desc_bad(rd_desc)) begin
              state_q    <= S_ERR;
              err_code_q <= ERR_DESC;
            end else begin
              state_q   <= S_LOAD;
              ld_req_q  <= 1'b1;
              ld_mode_q <= (cur_layer_q == '0) ?
                           LD_MODE_IFMAP_W : LD_MODE_W;
              wdog_q    <= '0;
            end
          end
          S_LOAD: begin
            if (ld_done) begin
              state_q    <= S_CFG;
              ld_req_q   <= 1'b0;
              ld_mode_q  <= 2'b00;
              cfg_we_q   <= 1'b1;
              cfg_reg0_q <= pack_reg0(rd_desc);
              cfg_reg1_q <= pack_reg1(rd_desc);
            end else if (wdog_hit) begin
              state_q    <= S_ERR;
              err_code_q <= ERR_TIMEOUT;
              ld_req_q   <= 1'b0;
              ld_mode_q  <= 2'b00;
            end else begin
              wdog_q <= wdog_q + TW'(1);
            end
          end
          S_CFG: begin
            state_q   <= S_RUN;
            conv_en_q <= 1'b1;
          end
          S_RUN: begin
            state_q <= S_WAIT;
            wdog_q  <= '0;
          end
          S_WAIT: begin
            if (conv_done) begin
              if (last_layer) begin
                state_q     <= S_DRAIN;
                drain_req_q <= 1'b1;
                wdog_q      <= '0;
              end else begin
                cur_layer_q <= cur_layer_q + AW'(1);
                state_q     <= S_CHECK;
              end
            end else if (wdog_hit) begin
              state_q    <= S_ERR;
              err_code_q <= ERR_TIMEOUT;
            end else begin
              wdog_q <= wdog_q + TW'(1);
            end
          end
          S_DRAIN: begin
            if (drain_last) begin
              state_q     <= S_IDLE;
              drain_req_q <= 1'b0;
              done_q      <= 1'b1;
            end else if (wdog_hit) begin
              state_q     <= S_ERR;
              err_code_q  <= ERR_TIMEOUT;
              drain_req_q <= 1'b0;
            end else begin
              wdog_q <= wdog_q + TW'(1);
            end
          end
          S_ERR: begin
            state_q <= S_ERR;
          end
        endcase
      end
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err       = (state_q == S_ERR);
  assign err_code  = err_code_q;
  assign done      = done_q;
  assign cur_layer = cur_layer_q;
  assign ld_req    = ld_req_q;
  assign ld_mode   = ld_mode_q;
  assign cfg_we    = cfg_we_q;
  assign cfg_reg0  = cfg_reg0_q;
  assign cfg_reg1  = cfg_reg1_q;
  assign conv_en   = conv_en_q;
  assign drain_req = drain_req_q;

endmodule
